// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence-detector front end.
//   ser_state_t    : word_serializer FSM states
//   DEFAULT_WORD_W : default serializer word width
package seq_pkg;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } ser_state_t;

    localparam int DEFAULT_WORD_W = 8;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end for the sequence detector.
// Accepts W-bit words over a valid/ready handshake and emits them one bit per
// clock, LSB first, on `a`. A one-word hold buffer lets back-to-back words
// stream with no gap cycles.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous active-high reset
//   clear      in   1  synchronous abort, drops shifter and hold contents
//   in_word    in   W  parallel word to serialize
//   in_valid   in   1  in_word is valid this cycle
//   in_ready   out  1  a word can be accepted this cycle (combinational)
//   a          out  1  serial bit (0 when a_valid is low)
//   a_valid    out  1  a carries a live bit
//   word_start out  1  a carries bit 0 of a word
module word_serializer
    import seq_pkg::*;
#(
    parameter int W = DEFAULT_WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] in_word,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         a,
    output logic         a_valid,
    output logic         word_start
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(W - 1);

    ser_state_t     state_reg, state_next;
    logic [W-1:0]   shift_reg, shift_next;
    logic [W-1:0]   hold_reg, hold_next;
    logic           hold_full_reg, hold_full_next;
    logic [CNT_W-1:0] bit_idx_reg, bit_idx_next;
    logic           a_reg, a_next;
    logic           a_valid_reg, a_valid_next;
    logic           word_start_reg, word_start_next;

    logic           accept;
    logic           load_en;
    logic [W-1:0]   load_word;

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_full_next  = hold_full_reg;
        bit_idx_next    = bit_idx_reg;
        a_next          = a_reg;
        a_valid_next    = a_valid_reg;
        word_start_next = word_start_reg;
        load_en         = 1'b0;
        load_word       = in_word;

        in_ready = !hold_full_reg && !clear && !reset;
        accept   = in_valid && in_ready;

        if (clear) begin
            state_next      = S_IDLE;
            shift_next      = '0;
            hold_next       = '0;
            hold_full_next  = 1'b0;
            bit_idx_next    = '0;
            a_next          = 1'b0;
            a_valid_next    = 1'b0;
            word_start_next = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        load_en   = 1'b1;
                        load_word = in_word;
                    end
                end
                S_SHIFT: begin
                    if (bit_idx_reg == LAST_IDX) begin
                        // Last bit on the wire: reload from hold first; a bypass
                        // accept can only happen when hold is empty.
                        if (hold_full_reg) begin
                            load_en        = 1'b1;
                            load_word      = hold_reg;
                            hold_full_next = 1'b0;
                        end else if (accept) begin
                            load_en   = 1'b1;
                            load_word = in_word;
                        end else begin
                            state_next      = S_IDLE;
                            bit_idx_next    = '0;
                            a_next          = 1'b0;
                            a_valid_next    = 1'b0;
                            word_start_next = 1'b0;
                        end
                    end else begin
                        // shift_reg holds the bits not yet driven, next one at [0]
                        a_next          = shift_reg[0];
                        shift_next      = shift_reg >> 1;
                        bit_idx_next    = bit_idx_reg + CNT_W'(1);
                        word_start_next = 1'b0;
                        if (accept) begin
                            hold_next      = in_word;
                            hold_full_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase

            // A load puts bit 0 on the wire at the same edge it is accepted.
            if (load_en) begin
                state_next      = S_SHIFT;
                a_next          = load_word[0];
                shift_next      = load_word >> 1;
                bit_idx_next    = '0;
                a_valid_next    = 1'b1;
                word_start_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            shift_reg      <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            bit_idx_reg    <= '0;
            a_reg          <= 1'b0;
            a_valid_reg    <= 1'b0;
            word_start_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_full_reg  <= hold_full_next;
            bit_idx_reg    <= bit_idx_next;
            a_reg          <= a_next;
            a_valid_reg    <= a_valid_next;
            word_start_reg <= word_start_next;
        end
    end

    assign a          = a_reg;
    assign a_valid    = a_valid_reg;
    assign word_start = word_start_reg;

endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer (W = 8).
module tb_word_serializer;

    logic       clk;
    logic       reset;
    logic       clear;
    logic [7:0] in_word;
    logic       in_valid;
    logic       in_ready;
    logic       a;
    logic       a_valid;
    logic       word_start;

    int n_tests = 0;
    int n_fail  = 0;

    word_serializer #(.W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .a_valid    (a_valid),
        .word_start (word_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ea, input logic ev, input logic es);
        check({tag, ".a"}, {31'd0, a}, {31'd0, ea});
        check({tag, ".a_valid"}, {31'd0, a_valid}, {31'd0, ev});
        check({tag, ".word_start"}, {31'd0, word_start}, {31'd0, es});
    endtask

    // 8'h6B LSB first = 1,1,0,1,0,1,1,0 ; 8'hFB LSB first = 1,1,0,1,1,1,1,1
    logic [15:0] stream;
    logic [7:0]  w6b;

    initial begin
        stream   = 16'hFB6B;
        w6b      = 8'h6B;
        reset    = 1'b1;
        clear    = 1'b0;
        in_word  = 8'h00;
        in_valid = 1'b0;
        #1;
        check("rst.in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check_out("rst.init", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("rst.in_ready_high", {31'd0, in_ready}, 32'd1);

        // ---- Test 2: single word 8'h6B
        tick();
        in_valid = 1'b1;
        in_word  = 8'h6B;
        check("t2.in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            in_valid = 1'b0;
            in_word  = 8'h00;   // must not disturb the word being shifted
            check_out($sformatf("t2.bit%0d", i), w6b[i], 1'b1, i == 0);
        end
        tick();
        check_out("t2.after", 1'b0, 1'b0, 1'b0);
        tick();
        check_out("t2.after2", 1'b0, 1'b0, 1'b0);

        // ---- Test 3: in_valid held, 6B then FB through the hold buffer
        in_valid = 1'b1;
        in_word  = 8'h6B;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) in_word = 8'hFB;
            if (i == 8) in_valid = 1'b0;
            check_out($sformatf("t3.bit%0d", i), stream[i], 1'b1, (i == 0) || (i == 8));
            if (i >= 1 && i <= 7)
                check($sformatf("t3.in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            else
                check($sformatf("t3.in_ready%0d", i), {31'd0, in_ready}, 32'd1);
        end
        tick();
        check_out("t3.after", 1'b0, 1'b0, 1'b0);

        // ---- Test 4: bypass load on the last-bit cycle
        in_valid = 1'b1;
        in_word  = 8'h6B;
        for (int i = 0; i < 16; i++) begin
            tick();
            in_valid = 1'b0;
            if (i == 7) begin
                in_valid = 1'b1;
                in_word  = 8'hFB;
                check("t4.ready_last", {31'd0, in_ready}, 32'd1);
            end
            check_out($sformatf("t4.bit%0d", i), stream[i], 1'b1, (i == 0) || (i == 8));
        end
        tick();
        check_out("t4.after", 1'b0, 1'b0, 1'b0);

        // ---- Test 5: clear after 3 bits with FB held
        in_valid = 1'b1;
        in_word  = 8'h6B;
        tick();
        in_word = 8'hFB;
        tick();
        in_valid = 1'b0;
        check("t5.hold_full", {31'd0, in_ready}, 32'd0);
        tick();
        check_out("t5.bit2", 1'b0, 1'b1, 1'b0);
        clear = 1'b1;
        #1;
        check("t5.ready_in_clear", {31'd0, in_ready}, 32'd0);
        tick();
        clear = 1'b0;
        #1;
        check_out("t5.cleared", 1'b0, 1'b0, 1'b0);
        check("t5.in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t5.idle%0d", i), {31'd0, a_valid}, 32'd0);
        end

        // ---- Test 6: in_valid with clear at the same edge
        in_valid = 1'b1;
        in_word  = 8'hFF;
        clear    = 1'b1;
        #1;
        check("t6.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        clear    = 1'b0;
        check_out("t6.no_accept", 1'b0, 1'b0, 1'b0);
        tick();
        check_out("t6.stay_idle", 1'b0, 1'b0, 1'b0);

        // ---- Test 1: reset asserted mid-cycle, mid-word
        in_valid = 1'b1;
        in_word  = 8'h6B;
        tick();
        in_valid = 1'b0;
        check_out("t1.pre", 1'b1, 1'b1, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check_out("t1.async", 1'b0, 1'b0, 1'b0);
        check("t1.ready_in_reset", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("t1.ready_after", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_out($sformatf("t1.no_resume%0d", i), 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
